// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_sequencer
// Description : APU frame counter ($4017). Divides the CPU-cycle enable into
//               quarter-frame and half-frame pulses and raises the frame IRQ.
//               Optional macro FRAME_SEQ_WRITE_DELAY_EN delays the counter
//               reset after a $4017 write by 3 or 4 CPU cycles (parity based).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
  parameter int STEP1 = 7457,
  parameter int STEP2 = 14913,
  parameter int STEP3 = 22371,
  parameter int STEP4 = 29829,
  parameter int STEP5 = 37281,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_ce,
  input  logic       wr_4017,
  input  logic [7:0] wr_data,
  input  logic       rd_4015,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       irq_n,
  output logic       mode
);

  localparam logic [CNT_W-1:0] S1  = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2  = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3  = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4  = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5  = CNT_W'(STEP5);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cyc;
  logic             inhibit;
  logic             reset_now;   // this cpu_ce forces cyc to 0 (write-triggered)

  // Only mode and inhibit bits of the write data are meaningful
  logic unused_wr_bits;
  assign unused_wr_bits = &{1'b0, wr_data[5:0]};

`ifdef FRAME_SEQ_WRITE_DELAY_EN
  logic       parity;
  logic [2:0] dly;             // cpu_ce count remaining until the counter reset

  assign reset_now = cpu_ce && (dly == 3'd1);

  // Parity toggle and write-to-reset countdown; a new write restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
      dly    <= 3'd0;
    end else begin
      if (cpu_ce) parity <= ~parity;
      if (wr_4017)
        dly <= parity ? 3'd3 : 3'd4;
      else if (cpu_ce && (dly != 3'd0))
        dly <= dly - 3'd1;
    end
  end
`else
  logic pend;

  assign reset_now = cpu_ce && pend;

  // Pending counter reset: armed by any write, consumed by the next cpu_ce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend <= 1'b0;
    else if (wr_4017)
      pend <= 1'b1;
    else if (cpu_ce)
      pend <= 1'b0;
  end
`endif

  // Step decode from the current count; the final step depends on mode
  logic at_s1, at_s2, at_s3, at_s4, at_s5;
  logic at_wrap, ev_quarter, ev_half, irq_set, irq_clr, irq_next;

  assign at_s1 = (cyc == S1);
  assign at_s2 = (cyc == S2);
  assign at_s3 = (cyc == S3);
  assign at_s4 = (cyc == S4);
  assign at_s5 = (cyc == S5);

  // >= keeps the counter bounded if mode drops to 0 while cyc is past STEP4
  assign at_wrap = mode ? (cyc >= S5) : (cyc >= S4);

  // The counter reset in 5-step mode also clocks the units immediately
  assign ev_half    = at_s2 | (at_s4 & ~mode) | (at_s5 & mode) | (reset_now & mode);
  assign ev_quarter = at_s1 | at_s3 | ev_half;

  // Set has priority over either clear source
  assign irq_set  = cpu_ce & at_s4 & ~mode & ~inhibit;
  assign irq_clr  = rd_4015 | (wr_4017 & wr_data[6]);
  assign irq_next = irq_set | (frame_irq & ~irq_clr);

  // Counter, mode/inhibit latches, registered pulses and IRQ flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc           <= '0;
      mode          <= 1'b0;
      inhibit       <= 1'b0;
      frame_irq     <= 1'b0;
      irq_n         <= 1'b1;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
    end else begin
      quarter_frame <= cpu_ce & ev_quarter;
      half_frame    <= cpu_ce & ev_half;
      frame_irq     <= irq_next;
      irq_n         <= ~irq_next;
      if (wr_4017) begin
        mode    <= wr_data[7];
        inhibit <= wr_data[6];
      end
      if (cpu_ce)
        cyc <= (reset_now || at_wrap) ? '0 : cyc + ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sequencer
// Description : Directed self-checking bench for frame_sequencer. Uses short
//               step counts (7/15/22/29/37) so several frames fit in a short
//               run; "v" in comments is the counter value after the last edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_ce = 1'b0;
  logic       wr_4017 = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_4015 = 1'b0;
  logic       quarter_frame, half_frame, frame_irq, irq_n, mode;

  int n_assert = 0;
  int n_fail   = 0;
  int qcnt     = 0;
  int hcnt     = 0;

  frame_sequencer #(
    .STEP1(7), .STEP2(15), .STEP3(22), .STEP4(29), .STEP5(37), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_ce(cpu_ce), .wr_4017(wr_4017),
    .wr_data(wr_data), .rd_4015(rd_4015), .quarter_frame(quarter_frame),
    .half_frame(half_frame), .frame_irq(frame_irq), .irq_n(irq_n), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and tally pulses
  task automatic tick();
    @(posedge clk);
    #1;
    if (quarter_frame === 1'b1) qcnt++;
    if (half_frame === 1'b1) hcnt++;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    qcnt = 0;
    hcnt = 0;
  endtask

  // n CPU cycles with cpu_ce high one clk in three
  task automatic ce3(input int n);
    repeat (n) begin
      cpu_ce = 1'b1; tick();
      cpu_ce = 1'b0; tick(); tick();
    end
  endtask

  task automatic write(input logic [7:0] d);
    wr_4017 = 1'b1; wr_data = d;
    tick();
    wr_4017 = 1'b0; wr_data = 8'h00;
  endtask

  initial begin
    // ---- reset state ----
    adv(2);
    chk("rst_qf", quarter_frame, 0);
    chk("rst_hf", half_frame, 0);
    chk("rst_irq", frame_irq, 0);
    chk("rst_irq_n", irq_n, 1);
    chk("rst_mode", mode, 0);
    rst_n = 1'b1; cpu_ce = 1'b1;                 // v=0

    // ---- mode 0 frame ----
    clr(); adv(7);  chk("m0_pre_s1_q", qcnt, 0);
    tick();         chk("m0_s1_q", quarter_frame, 1); chk("m0_s1_h", half_frame, 0);
    clr(); adv(7);  chk("m0_pre_s2_q", qcnt, 0);     // v=15
    tick();         chk("m0_s2_q", quarter_frame, 1); chk("m0_s2_h", half_frame, 1);
    clr(); adv(6);  chk("m0_pre_s3_h", hcnt, 0);
    tick();         chk("m0_s3_q", quarter_frame, 1); chk("m0_s3_h", half_frame, 0);
    adv(6);         chk("m0_pre_s4_irq", frame_irq, 0);   // v=29
    rd_4015 = 1'b1;                               // clear in same clk as set
    tick();         rd_4015 = 1'b0;
    chk("m0_s4_q", quarter_frame, 1); chk("m0_s4_h", half_frame, 1);
    chk("set_wins_irq", frame_irq, 1); chk("set_wins_irq_n", irq_n, 0);

    // ---- read clear while frozen ----
    cpu_ce = 1'b0; rd_4015 = 1'b1;
    tick();         rd_4015 = 1'b0;
    chk("rd_clr_irq", frame_irq, 0); chk("rd_clr_irq_n", irq_n, 1);
    clr(); adv(5);  chk("freeze_q", qcnt, 0);

    // ---- second frame: period 30 ----
    cpu_ce = 1'b1;
    clr(); adv(7);  chk("f2_pre_s1_q", qcnt, 0);
    tick();         chk("f2_s1_q", quarter_frame, 1);    // v=8
    clr(); adv(21); chk("f2_mid_q", qcnt, 2); chk("f2_mid_h", hcnt, 1);
    tick();         chk("f2_s4_irq", frame_irq, 1);      // v=0

`ifdef FRAME_SEQ_WRITE_DELAY_EN
    // ---- delayed reset: restart from a known parity ----
    rst_n = 1'b0; tick(); rst_n = 1'b1;          // parity 0, v=0
    cpu_ce = 1'b0; write(8'h00);                 // even parity: 4 cpu_ce delay
    cpu_ce = 1'b1; adv(4);                       // 0,1,2 then reset -> v=0
    clr(); adv(7);  chk("dly4_pre_q", qcnt, 0);
    tick();         chk("dly4_s1_q", quarter_frame, 1);  // v=8, parity 0
    adv(1);                                       // v=9, parity 1
    cpu_ce = 1'b0; write(8'h00);                 // odd parity: 3 cpu_ce delay
    cpu_ce = 1'b1; adv(3);                       // 9,10 then reset -> v=0
    clr(); adv(7);  chk("dly3_pre_q", qcnt, 0);
    tick();         chk("dly3_s1_q", quarter_frame, 1);
`else
    // ---- inhibit write clears flag, no IRQ for two frames ----
    cpu_ce = 1'b0; write(8'h40);
    chk("inh_clr_irq", frame_irq, 0); chk("inh_mode", mode, 0);
    cpu_ce = 1'b1; tick();                       // pending reset, v=0
    clr(); adv(60);
    chk("inh_irq", frame_irq, 0); chk("inh_q", qcnt, 8); chk("inh_h", hcnt, 4);

    // ---- un-inhibit: IRQ at step 4 after the write ----
    write(8'h00);                                // processes 0, v=1
    tick();                                      // reset, v=0
    adv(29);        chk("uninh_pre_irq", frame_irq, 0);
    tick();         chk("uninh_irq", frame_irq, 1);      // v=0

    // ---- back-to-back writes, 5-step mode ----
    cpu_ce = 1'b0; write(8'h40);
    chk("w40_clr_irq", frame_irq, 0);
    write(8'h80);
    cpu_ce = 1'b1; tick();
    chk("imm_q", quarter_frame, 1); chk("imm_h", half_frame, 1); chk("m1_mode", mode, 1);
    clr(); adv(7);  chk("m1_pre_s1_q", qcnt, 0);
    tick();         chk("m1_s1_q", quarter_frame, 1);    // v=8
    clr(); adv(21); chk("m1_mid_q", qcnt, 2); chk("m1_mid_h", hcnt, 1);
    tick();         chk("m1_s4_q", quarter_frame, 0); chk("m1_s4_irq", frame_irq, 0);
    clr(); adv(7);  chk("m1_pre_s5_q", qcnt, 0);
    tick();         chk("m1_s5_q", quarter_frame, 1); chk("m1_s5_h", half_frame, 1);
    clr(); adv(76);
    chk("m1_2f_q", qcnt, 8); chk("m1_2f_h", hcnt, 4); chk("m1_2f_irq", frame_irq, 0);
    clr(); adv(7);  chk("m1_f4_pre_q", qcnt, 0);
    tick();         chk("m1_f4_s1_q", quarter_frame, 1); // v=8

    // ---- sparse cpu_ce, mid-frame write 0x00 ----
    ce3(2);                                      // v=10
    cpu_ce = 1'b0; write(8'h00);
    cpu_ce = 1'b1; tick();
    chk("sp_rst_q", quarter_frame, 0); chk("sp_mode", mode, 0);
    cpu_ce = 1'b0; tick(); tick();               // v=0
    clr(); ce3(7);  chk("sp_pre_q", qcnt, 0);
    cpu_ce = 1'b1; tick(); chk("sp_s1_q", quarter_frame, 1);
    cpu_ce = 1'b0; tick(); chk("sp_s1_width", quarter_frame, 0);
    tick();                                      // v=8
    clr(); ce3(8);  chk("sp_s2_qw", qcnt, 1); chk("sp_s2_hw", hcnt, 1);   // v=16

    // ---- write on a step-event cpu_ce ----
    cpu_ce = 1'b1; adv(6);                       // v=22
    write(8'h00);   chk("wev_q", quarter_frame, 1);
    tick();         chk("wev_rst_q", quarter_frame, 0);  // v=0
    clr(); adv(7);  chk("wev_pre_q", qcnt, 0);
    tick();         chk("wev_s1_q", quarter_frame, 1);   // v=8

    // ---- async reset mid-frame ----
    write(8'h80); tick();                         // immediate clock, v=0
    adv(15); tick();
    chk("ar_pre_h", half_frame, 1);               // v=16
    rst_n = 1'b0; #1;
    chk("ar_q", quarter_frame, 0); chk("ar_h", half_frame, 0);
    chk("ar_mode", mode, 0); chk("ar_irq_n", irq_n, 1);
    tick(); tick();
    rst_n = 1'b1;
    clr(); adv(7);  chk("ar_pre_q", qcnt, 0);
    tick();         chk("ar_s1_q", quarter_frame, 1);
    adv(21); tick(); chk("ar_s4_irq", frame_irq, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
